seq_hit_monitor: RTL and testbench
==================================

// Module: seq_hit_monitor
// PURPOSE
//  Downstream stage of the serial sequence detector. Consumes its 1-cycle Mealy
//  match pulse and keeps a saturating hit count and the gap between consecutive hits.
//  Raises an acknowledged interrupt when a burst of closely spaced hits occurs.
//  Sits between the detector and the host/status logic.
// PARAMETERS
//  CNT_W      8  width of hit_count
//  GAP_W      8  width of gap_last and of the internal gap counter
//  BURST_N    3  hits per burst; legal range 2 .. 2**CNT_W-1
//  BURST_GAP  5  max gap in cycles between hits of one burst; legal range 1 .. 2**GAP_W-1
// PORTS
//  clock      in   1      single clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  hit_in     in   1      match pulse from detector (dataout), sampled each posedge
//  enable     in   1      1 = monitor active; 0 = freeze all state
//  clear      in   1      synchronous soft clear of counters/state
//  irq_ack    in   1      host acknowledge of irq
//  hit_count  out  CNT_W  hits sampled since reset/clear, saturating
//  gap_last   out  GAP_W  cycles between the two most recent hits, saturating
//  irq        out  1      burst interrupt, level, held until acknowledged
//  overflow   out  1      sticky: hit seen while hit_count at max
//  state      out  2      debug: 00 IDLE, 01 TRACK, 10 ALERT
// BEHAVIOUR
//  - All outputs are registered. A hit sampled at edge N is reflected after edge N.
//  - Reset (highest priority), then clear: hit_count=0, gap_last=0, gap_cnt=0,
//    run=0, irq=0, overflow=0, state=IDLE. A hit in the same cycle is dropped.
//  - enable=0 (below reset/clear): hit_in ignored; gap_cnt, run, state, irq and
//    counters hold. irq_ack is still honoured.
//  - Every sampled hit: hit_count+1, saturating at 2**CNT_W-1. If already at
//    max, hold and set overflow (sticky until reset/clear).
//  - gap_cnt is loaded with 1 on each hit. It increments (saturating) on each
//    enabled non-hit cycle while state != IDLE. On a hit in TRACK/ALERT,
//    gap_last <= gap_cnt before the reload. Example: hits at cycles 10 and 15
//    give gap_last=5.
//  - run = hits in the current burst candidate (saturating at BURST_N).
//  - IDLE: no hit since reset/clear. On hit: run<=1, go to TRACK.
//  - TRACK: on hit with gap_cnt<=BURST_GAP: run<=run+1. On hit with
//    gap_cnt>BURST_GAP: run<=1.
//    If the new run value == BURST_N: irq<=1 and go to ALERT at the same edge.
//  - ALERT: irq=1. Hits are still counted and gap_last still updates; burst
//    detection is suspended and run holds.
//    On irq_ack: irq<=0, run<=0, go to TRACK.
//    Ack and hit in the same cycle: hit is counted, run<=1.
//  - irq_ack outside ALERT has no effect.
//  - reset or clear mid-burst or in ALERT aborts to IDLE with irq=0.
// TESTING
//  1. reset; hits at cycles 10,15 (BURST_GAP=5, BURST_N=3)
//     -> hit_count=2, gap_last=5, state=TRACK, irq=0.
//  2. hits at 0,4,8 -> irq=1 and state=ALERT after the edge sampling the hit
//     at 8; irq_ack at 12 -> irq=0, state=TRACK after edge 12.
//  3. hits at 0,4,20,24 -> gap 16 breaks the run; irq stays 0, gap_last=4,
//     hit_count=4.
//  4. CNT_W=8, 256 hits spaced 10 apart -> hit_count=255, overflow=1 after the
//     256th hit; clear -> both 0.
//  5. GAP_W=8, hits 300 cycles apart -> gap_last=255 (saturated).
//  6. clear asserted with hit_in=1 -> all outputs 0, state=IDLE.
//     enable=0 with 5 hits -> no change; then enable=1 and ack in ALERT
//     together with a hit -> count+1, irq=0.

Source files
------------

// File: rtl/seq_hit_monitor.sv
// Burst/gap monitor downstream of the serial sequence detector: counts match pulses,
// measures spacing between hits and raises an acknowledged interrupt on a burst.
module seq_hit_monitor #(
   parameter int CNT_W     = 8,
   parameter int GAP_W     = 8,
   parameter int BURST_N   = 3,
   parameter int BURST_GAP = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             hit_in,
   input  logic             enable,
   input  logic             clear,
   input  logic             irq_ack,
   output logic [CNT_W-1:0] hit_count,
   output logic [GAP_W-1:0] gap_last,
   output logic             irq,
   output logic             overflow,
   output logic [1:0]       state
);

   localparam int RUN_W = $clog2(BURST_N + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [GAP_W-1:0] GAP_MAX     = '1;
   localparam logic [GAP_W-1:0] BURST_GAP_C = GAP_W'(BURST_GAP);
   localparam logic [RUN_W-1:0] BURST_N_C   = RUN_W'(BURST_N);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      TRACK = 2'b01,
      ALERT = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [GAP_W-1:0] gap_last_q, gap_last_d;
   logic [RUN_W-1:0] run_q, run_d, run_next;
   logic             irq_q, irq_d;
   logic             ovf_q, ovf_d;
   logic             hit;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would create order races.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         gap_cnt_q  <= '0;
         gap_last_q <= '0;
         run_q      <= '0;
         irq_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         gap_cnt_q  <= gap_cnt_d;
         gap_last_q <= gap_last_d;
         run_q      <= run_d;
         irq_q      <= irq_d;
         ovf_q      <= ovf_d;
      end
   end

   // NOTE: every combinational output gets a hold default first, so no path
   // through the case/if tree can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      gap_cnt_d  = gap_cnt_q;
      gap_last_d = gap_last_q;
      run_d      = run_q;
      irq_d      = irq_q;
      ovf_d      = ovf_q;
      run_next   = '0;
      hit        = enable & hit_in;

      if (clear) begin
         state_d    = IDLE;
         count_d    = '0;
         gap_cnt_d  = '0;
         gap_last_d = '0;
         run_d      = '0;
         irq_d      = 1'b0;
         ovf_d      = 1'b0;
      end else begin
         if (hit) begin
            if (count_q == CNT_MAX) ovf_d = 1'b1;
            else                    count_d = count_q + CNT_W'(1);
            gap_cnt_d = GAP_W'(1);
         end else if (enable && state_q != IDLE && gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (hit) begin
                  run_d   = RUN_W'(1);
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (hit) begin
                  gap_last_d = gap_cnt_q;
                  run_next   = (gap_cnt_q <= BURST_GAP_C) ? run_q + RUN_W'(1) : RUN_W'(1);
                  run_d      = run_next;
                  if (run_next == BURST_N_C) begin
                     irq_d   = 1'b1;
                     state_d = ALERT;
                  end
               end
            end
            ALERT: begin
               // Burst detection is suspended here; the ack restarts the run,
               // seeding it with a hit taken in the same cycle.
               if (hit) gap_last_d = gap_cnt_q;
               if (irq_ack) begin
                  irq_d   = 1'b0;
                  run_d   = hit ? RUN_W'(1) : RUN_W'(0);
                  state_d = TRACK;
               end
            end
            default: begin
               state_d = IDLE;
               irq_d   = 1'b0;
               run_d   = '0;
            end
         endcase
      end
   end

   assign hit_count = count_q;
   assign gap_last  = gap_last_q;
   assign irq       = irq_q;
   assign overflow  = ovf_q;
   assign state     = state_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed bench for seq_hit_monitor with default parameters (8/8, burst of 3 within 5 cycles).
module tb_seq_hit_monitor;

   logic       clock = 1'b0;
   logic       reset, hit_in, enable, clear, irq_ack;
   logic [7:0] hit_count, gap_last;
   logic       irq, overflow;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   seq_hit_monitor #(.CNT_W(8), .GAP_W(8), .BURST_N(3), .BURST_GAP(5)) dut (
      .clock(clock), .reset(reset), .hit_in(hit_in), .enable(enable),
      .clear(clear), .irq_ack(irq_ack), .hit_count(hit_count),
      .gap_last(gap_last), .irq(irq), .overflow(overflow), .state(state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock cycle with the given hit/ack; outputs are stable 1 time unit after the edge.
   task automatic tick(input logic h, input logic a);
      hit_in  = h;
      irq_ack = a;
      @(posedge clock);
      #1;
      hit_in  = 1'b0;
      irq_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   task automatic do_clear(input logic h);
      clear = 1'b1;
      tick(h, 1'b0);
      clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; hit_in = 1'b0; enable = 1'b1; clear = 1'b0; irq_ack = 1'b0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check("rst_count", hit_count, 0);
      check("rst_gap",   gap_last,  0);
      check("rst_irq",   irq,       0);
      check("rst_ovf",   overflow,  0);
      check("rst_state", state,     0);
      reset = 1'b0;

      // Hits at cycles 10 and 15.
      idle(9); tick(1'b1, 1'b0); idle(4); tick(1'b1, 1'b0);
      check("t1_count", hit_count, 2);
      check("t1_gap",   gap_last,  5);
      check("t1_state", state,     1);
      check("t1_irq",   irq,       0);

      // Hits at 0,4,8 form a burst; ack at 12.
      do_clear(1'b0);
      tick(1'b1, 1'b0); idle(3); tick(1'b1, 1'b0); idle(3); tick(1'b1, 1'b0);
      check("t2_irq",   irq,       1);
      check("t2_state", state,     2);
      check("t2_gap",   gap_last,  4);
      check("t2_count", hit_count, 3);
      idle(3); tick(1'b0, 1'b1);
      check("t2_ack_irq",   irq,   0);
      check("t2_ack_state", state, 1);
      tick(1'b0, 1'b1);
      check("t2_stray_ack_state", state, 1);
      check("t2_stray_ack_irq",   irq,   0);

      // Hits at 0,4,20,24: the 16-cycle gap restarts the run.
      do_clear(1'b0);
      tick(1'b1, 1'b0); idle(3); tick(1'b1, 1'b0); idle(15);
      tick(1'b1, 1'b0);
      check("t3_gap16", gap_last, 16);
      idle(3); tick(1'b1, 1'b0);
      check("t3_irq",   irq,       0);
      check("t3_gap",   gap_last,  4);
      check("t3_count", hit_count, 4);
      check("t3_state", state,     1);

      // Saturation of hit_count and sticky overflow.
      do_clear(1'b0);
      for (int i = 0; i < 255; i++) begin
         tick(1'b1, 1'b0);
         idle(9);
      end
      check("t4_count255", hit_count, 255);
      check("t4_ovf_pre",  overflow,  0);
      tick(1'b1, 1'b0);
      check("t4_count_sat", hit_count, 255);
      check("t4_ovf",       overflow,  1);
      check("t4_irq",       irq,       0);
      do_clear(1'b0);
      check("t4_clr_count", hit_count, 0);
      check("t4_clr_ovf",   overflow,  0);
      check("t4_clr_state", state,     0);

      // Gap counter saturation with hits 300 cycles apart.
      tick(1'b1, 1'b0); idle(299); tick(1'b1, 1'b0);
      check("t5_gap_sat", gap_last,  255);
      check("t5_count",   hit_count, 2);

      // Clear wins over a simultaneous hit.
      do_clear(1'b1);
      check("t6_clr_count", hit_count, 0);
      check("t6_clr_gap",   gap_last,  0);
      check("t6_clr_irq",   irq,       0);
      check("t6_clr_ovf",   overflow,  0);
      check("t6_clr_state", state,     0);

      // Enter ALERT, then freeze with enable=0 while hits arrive.
      tick(1'b1, 1'b0); idle(1); tick(1'b1, 1'b0); idle(1); tick(1'b1, 1'b0);
      check("t6_alert_state", state, 2);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      check("t6_frz_count", hit_count, 3);
      check("t6_frz_irq",   irq,       1);
      check("t6_frz_state", state,     2);
      enable = 1'b1;
      tick(1'b1, 1'b1);
      check("t6_ackhit_count", hit_count, 4);
      check("t6_ackhit_irq",   irq,       0);
      check("t6_ackhit_state", state,     1);
      check("t6_ackhit_gap",   gap_last,  1);
      // run restarted at 1, so two more close hits complete a new burst.
      idle(1); tick(1'b1, 1'b0);
      check("t6_run2_irq", irq, 0);
      idle(1); tick(1'b1, 1'b0);
      check("t6_run3_irq",   irq,   1);
      check("t6_run3_state", state, 2);

      // Clear in ALERT aborts to IDLE.
      do_clear(1'b0);
      check("t6_abort_irq",   irq,   0);
      check("t6_abort_state", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
